// File: rtl/e_nested_link_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : e_nested_link_rx_pkg
//  Description : Shared types and constants for the inAndOut narrow-link
//                receiver. The link carries one header beat followed by
//                PAY_BEATS payload beats of LINK_W bits each.
//  Revision    : 1.0 - initial release
// ============================================================================
package e_nested_link_rx_pkg;

    localparam int LINK_W    = 6;
    localparam int PAY_BEATS = 3;
    localparam int FRAME_W   = LINK_W * PAY_BEATS;

    typedef logic [LINK_W-1:0] linkBeatT;

    // Header carried in link_data[1:0]
    typedef struct packed {
        logic dest;     // addr_id_top of the target instance
        logic parity;   // XOR-reduce of the 18 payload bits
    } eHeaderSt;

    typedef struct packed {
        logic [1:0] variablec;
        logic [2:0] variablec2;
    } joeSt;

    // joe[1] occupies [9:5], joe[0] occupies [4:0]
    typedef struct packed {
        logic       variablea;
        logic [2:0] variabled;
        logic [3:0] variabled2;
        joeSt [1:0] joe;
    } eNestedSt;

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_PAY  = 2'd1,
        RX_HOLD = 2'd2
    } rxStateT;

endpackage : e_nested_link_rx_pkg
`default_nettype wire

// File: rtl/e_nested_link_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : e_nested_link_rx_if
//  Description : Handshake bundle of the link receiver.
//                link_valid/link_data/link_ready : inbound narrow link
//                out_valid/out_data/out_ready    : reassembled frame output
//                master = link transmitter + frame consumer side
//                slave  = receiver side
//  Revision    : 1.0 - initial release
// ============================================================================
interface e_nested_link_rx_if;
    import e_nested_link_rx_pkg::*;

    logic     link_valid;
    linkBeatT link_data;
    logic     link_ready;
    logic     out_valid;
    eNestedSt out_data;
    logic     out_ready;

    modport master (
        output link_valid,
        output link_data,
        input  link_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  link_valid,
        input  link_data,
        output link_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

endinterface : e_nested_link_rx_if
`default_nettype wire

// File: rtl/e_nested_link_rx_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter; holds at all-ones.
//                clk, rst_n (sync, active-low), inc (count enable),
//                count (current value)
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    output logic [CNT_W-1:0]      count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/e_nested_link_rx.sv
`default_nettype none
// ============================================================================
//  Module      : e_nested_link_rx
//  Description : Receive end of the inAndOut narrow link. Reassembles one
//                header beat plus three LSB-first payload beats into an
//                eNestedSt, checks parity and destination, and presents
//                good frames on a valid/ready port. Bad frames are dropped
//                and counted.
//                clk, rst_n      : clock, synchronous active-low reset
//                lnk (slave)     : link input and frame output handshakes
//                parity_err      : 1-cycle pulse on a parity-failed frame
//                frame_cnt       : frames delivered (saturating)
//                drop_cnt        : frames dropped (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module e_nested_link_rx
    import e_nested_link_rx_pkg::*;
#(
    parameter int INST_ID = 0,
    parameter int CNT_W   = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    e_nested_link_rx_if.slave     lnk,
    output logic                  parity_err,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam logic INST_BIT = (INST_ID != 0);

    rxStateT              state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    eHeaderSt             hdr_q, hdr_d;
    logic [FRAME_W-1:0]   asm_q, asm_d;
    logic                 perr_q, perr_d;
    logic                 frame_inc;
    logic                 drop_inc;
    logic                 beat;
    logic [FRAME_W-1:0]   frame_full;
    logic                 parity_ok;
    logic                 dest_ok;

    // Ready depends on state only so the transmitter never sees a
    // combinational path from its own valid.
    assign lnk.link_ready = (state_q != RX_HOLD);
    assign beat           = lnk.link_valid && lnk.link_ready;

    // The frame as it will look once the final beat lands, so it can be
    // judged in the same cycle the last beat is accepted.
    assign frame_full = {lnk.link_data, asm_q[2*LINK_W-1:0]};
    assign parity_ok  = ((^frame_full) == hdr_q.parity);
    assign dest_ok    = (hdr_q.dest == INST_BIT);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        asm_d     = asm_q;
        perr_d    = 1'b0;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            RX_HDR: begin
                if (beat) begin
                    hdr_d   = eHeaderSt'(lnk.link_data[1:0]);
                    idx_d   = 2'd0;
                    state_d = RX_PAY;
                end
            end

            RX_PAY: begin
                if (beat) begin
                    case (idx_q)
                        2'd0:    asm_d[LINK_W-1:0]          = lnk.link_data;
                        2'd1:    asm_d[2*LINK_W-1:LINK_W]   = lnk.link_data;
                        default: asm_d[FRAME_W-1:2*LINK_W]  = lnk.link_data;
                    endcase

                    if (idx_q == 2'(PAY_BEATS - 1)) begin
                        // Parity wins over destination so a doubly-bad
                        // frame is counted exactly once.
                        if (!parity_ok) begin
                            perr_d   = 1'b1;
                            drop_inc = 1'b1;
                            state_d  = RX_HDR;
                        end else if (!dest_ok) begin
                            drop_inc = 1'b1;
                            state_d  = RX_HDR;
                        end else begin
                            frame_inc = 1'b1;
                            state_d   = RX_HOLD;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            RX_HOLD: begin
                if (lnk.out_ready) begin
                    state_d = RX_HDR;
                end
            end

            default: begin
                state_d = RX_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_HDR;
            idx_q   <= 2'd0;
            hdr_q   <= '0;
            asm_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            asm_q   <= asm_d;
            perr_q  <= perr_d;
        end
    end

    // The assembly register is only rewritten from PAY, so it stays
    // stable for the whole HOLD period.
    assign lnk.out_valid = (state_q == RX_HOLD);
    assign lnk.out_data  = eNestedSt'(asm_q);
    assign parity_err    = perr_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_inc),
        .count (frame_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

endmodule : e_nested_link_rx
`default_nettype wire

// File: tb/tb_e_nested_link_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_nested_link_rx
//  Description : Self-checking bench for e_nested_link_rx. A second instance
//                with 2-bit counters shares the same link traffic to
//                exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_nested_link_rx;
    import e_nested_link_rx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e_nested_link_rx_if lif();
    e_nested_link_rx_if lif2();

    assign lif2.link_valid = lif.link_valid;
    assign lif2.link_data  = lif.link_data;
    assign lif2.out_ready  = lif.out_ready;

    logic       perr, perr2;
    logic [7:0] fcnt, dcnt;
    logic [1:0] fcnt2, dcnt2;

    e_nested_link_rx #(.INST_ID(0), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lnk        (lif),
        .parity_err (perr),
        .frame_cnt  (fcnt),
        .drop_cnt   (dcnt)
    );

    e_nested_link_rx #(.INST_ID(0), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .lnk        (lif2),
        .parity_err (perr2),
        .frame_cnt  (fcnt2),
        .drop_cnt   (dcnt2)
    );

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];
    int exp_frames = 0;
    int exp_drops  = 0;
    int exp_perr   = 0;
    int seen_perr  = 0;
    int ready_mode = 2;   // 0 random, 1 held low, 2 held high

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Consumer readiness, changed just after the clock edge
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       lif.out_ready = ($urandom_range(0, 3) != 0);
            1:       lif.out_ready = 1'b0;
            default: lif.out_ready = 1'b1;
        endcase
    end

    // Output monitor / scoreboard
    logic        prev_v, prev_r, prev_perr;
    logic [17:0] prev_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v    = 1'b0;
            prev_r    = 1'b0;
            prev_perr = 1'b0;
            prev_d    = '0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, lif.out_valid}, 32'd1);
                chk("hold_data", {14'b0, lif.out_data}, {14'b0, prev_d});
            end
            if (lif.out_valid && lif.link_ready) begin
                chk("ready_in_hold", 32'd1, 32'd0);
            end
            if (lif.out_valid && lif.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {14'b0, lif.out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", {14'b0, lif.out_data}, {14'b0, exp_q.pop_front()});
                end
            end
            if (perr) begin
                seen_perr++;
                if (prev_perr) chk("perr_width", 32'd2, 32'd1);
            end
            prev_v    = lif.out_valid;
            prev_r    = lif.out_ready;
            prev_d    = lif.out_data;
            prev_perr = perr;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_beat(input logic [5:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        lif.link_valid = 1'b1;
        lif.link_data  = b;
        n = 0;
        while (!lif.link_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("beat_timeout", 32'd1, 32'd0);
        @(negedge clk);
        lif.link_valid = 1'b0;
        lif.link_data  = 6'($urandom);
    endtask

    task automatic send_frame(input logic [1:0] hdr, input logic [17:0] pay, input int maxgap);
        logic pok, dok;
        pok = (hdr[0] == ^pay);
        dok = (hdr[1] == 1'b0);
        if (pok && dok) begin
            exp_frames++;
            exp_q.push_back(pay);
        end else begin
            exp_drops++;
            if (!pok) exp_perr++;
        end
        send_beat({4'($urandom), hdr}, $urandom_range(0, maxgap));
        for (int i = 0; i < 3; i++) begin
            send_beat(pay[i*6 +: 6], $urandom_range(0, maxgap));
        end
        chk("parity_err", {31'b0, perr}, {31'b0, ~pok});
        chk("frame_cnt", {24'b0, fcnt}, sat(exp_frames, 255));
        chk("drop_cnt", {24'b0, dcnt}, sat(exp_drops, 255));
        chk("frame_cnt_sat", {30'b0, fcnt2}, sat(exp_frames, 3));
        chk("drop_cnt_sat", {30'b0, dcnt2}, sat(exp_drops, 3));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || lif.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_out_valid"}, {31'b0, lif.out_valid}, 32'd0);
        chk({nm, "_out_data"}, {14'b0, lif.out_data}, 32'd0);
        chk({nm, "_perr"}, {31'b0, perr}, 32'd0);
        chk({nm, "_fcnt"}, {24'b0, fcnt}, 32'd0);
        chk({nm, "_dcnt"}, {24'b0, dcnt}, 32'd0);
        chk({nm, "_link_ready"}, {31'b0, lif.link_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] pay;
        logic [1:0]  hdr;
        lif.link_valid = 1'b0;
        lif.link_data  = '0;
        lif.out_ready  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame; out_valid must be up right after the last beat
        send_frame(2'b01, 18'h15A5C, 0);
        chk("latency_valid", {31'b0, lif.out_valid}, 32'd1);
        chk("latency_data", {14'b0, lif.out_data}, 32'h15A5C);
        wait_drain();

        // Backpressure for 10 cycles
        ready_mode = 1;
        @(negedge clk);
        send_frame(2'b01, 18'h15A5C, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'b0, lif.out_valid}, 32'd1);
            chk("bp_data", {14'b0, lif.out_data}, 32'h15A5C);
            chk("bp_link_ready", {31'b0, lif.link_ready}, 32'd0);
            @(negedge clk);
        end
        ready_mode = 2;
        wait_drain();

        // Parity error, then wrong destination
        send_frame(2'b00, 18'h15A5C, 0);
        chk("perr_no_valid", {31'b0, lif.out_valid}, 32'd0);
        send_frame(2'b11, 18'h15A5C, 0);
        chk("dest_no_valid", {31'b0, lif.out_valid}, 32'd0);
        // Both errors at once: counted once
        send_frame(2'b10, 18'h15A5C, 0);

        // Reset in the middle of a frame
        send_beat(6'h01, 0);
        send_beat(6'h1C, 0);
        send_beat(6'h29, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_drops  = 0;
        check_idle("midreset");
        send_frame(2'b01, 18'h15A5C, 0);
        wait_drain();

        // Randomised traffic with backpressure and beat gaps
        ready_mode = 0;
        for (int f = 0; f < 60; f++) begin
            pay = 18'($urandom);
            hdr[0] = ($urandom_range(0, 4) == 0) ? ~(^pay) : (^pay);
            hdr[1] = ($urandom_range(0, 4) == 0);
            send_frame(hdr, pay, 2);
        end
        ready_mode = 2;
        wait_drain();
        repeat (3) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("perr_pulses", seen_perr, exp_perr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_e_nested_link_rx
`default_nettype wire
